// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the EX stage and the shared multiply/divide engine.
// EX drives the request side through the master modport; the engine answers through slave.
interface muldiv_unit_if #(
   parameter int WIDTH = 32,
   parameter int TAG_W = 5
);
   logic             op_valid;
   logic             op_ready;
   logic [1:0]       op;
   logic [WIDTH-1:0] src1;
   logic [WIDTH-1:0] src2;
   logic [TAG_W-1:0] tag_in;
   logic             annul;
   logic             busy;
   logic             res_valid;
   logic [WIDTH-1:0] res_hi;
   logic [WIDTH-1:0] res_lo;
   logic [TAG_W-1:0] res_tag;
   logic             div_by_zero;

   modport master (
      output op_valid, op, src1, src2, tag_in, annul,
      input  op_ready, busy, res_valid, res_hi, res_lo, res_tag, div_by_zero
   );

   modport slave (
      input  op_valid, op, src1, src2, tag_in, annul,
      output op_ready, busy, res_valid, res_hi, res_lo, res_tag, div_by_zero
   );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine with a single shared accumulator datapath.
// Define MULDIV_FAST_MUL_EN to replace the shift-add multiplier with a one-cycle product.
module muldiv_unit #(
   parameter int WIDTH = 32,
   parameter int TAG_W = 5
) (
   input  logic           i_clk,
   input  logic           i_resetn,
   muldiv_unit_if.slave   io_bus
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

   state_t             r_state, w_state_nxt;
   logic [CW-1:0]      r_cnt;
   logic [WIDTH-1:0]   r_a, r_b;
   logic [2*WIDTH-1:0] r_acc;
   logic               r_neg_q, r_neg_r;
   logic [TAG_W-1:0]   r_tag;
   logic [WIDTH-1:0]   r_res_hi, r_res_lo;
   logic [TAG_W-1:0]   r_res_tag;
   logic               r_dbz;

   logic               w_ready, w_busy, w_accept, w_is_div, w_signed;
   logic               w_s1, w_s2, w_dbz, w_last, w_finish;
   logic [WIDTH-1:0]   w_mag1, w_mag2;
   logic [2*WIDTH-1:0] w_mul_nxt, w_div_nxt, w_step, w_prod_fin;
   logic [WIDTH:0]     w_shift, w_diff;
   logic [WIDTH-1:0]   w_quo_fin, w_rem_fin;

   assign w_ready  = (r_state == S_IDLE) || (r_state == S_DONE);
   assign w_busy   = (r_state == S_MUL) || (r_state == S_DIV);
   assign w_accept = io_bus.op_valid & w_ready & ~io_bus.annul;
   assign w_is_div = io_bus.op[1];
   assign w_signed = ~io_bus.op[0];
   assign w_s1     = w_signed & io_bus.src1[WIDTH-1];
   assign w_s2     = w_signed & io_bus.src2[WIDTH-1];
   assign w_mag1   = w_s1 ? -io_bus.src1 : io_bus.src1;
   assign w_mag2   = w_s2 ? -io_bus.src2 : io_bus.src2;
   assign w_dbz    = w_is_div & (io_bus.src2 == '0);
   assign w_last   = (r_cnt == CW'(WIDTH-1));

`ifdef MULDIV_FAST_MUL_EN
   assign w_mul_nxt = {{WIDTH{1'b0}}, r_a} * {{WIDTH{1'b0}}, r_b};
`else
   // Shift-add: r_acc = {partial product, remaining multiplier bits}.
   logic [WIDTH:0] w_mul_sum;
   assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_a : {WIDTH{1'b0}})};
   assign w_mul_nxt = {w_mul_sum, r_acc[WIDTH-1:1]};
`endif

   // Restoring division: r_acc = {remainder, dividend bits still to shift in / quotient}.
   assign w_shift   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
   assign w_diff    = w_shift - {1'b0, r_b};
   assign w_div_nxt = w_diff[WIDTH] ? {w_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                    : {w_diff[WIDTH-1:0],  r_acc[WIDTH-2:0], 1'b1};

   assign w_step     = (r_state == S_DIV) ? w_div_nxt : w_mul_nxt;
   assign w_prod_fin = r_neg_q ? -w_step : w_step;
   assign w_quo_fin  = r_neg_q ? -w_step[WIDTH-1:0] : w_step[WIDTH-1:0];
   assign w_rem_fin  = r_neg_r ? -w_step[2*WIDTH-1:WIDTH] : w_step[2*WIDTH-1:WIDTH];
   assign w_finish   = w_busy & ~io_bus.annul & (w_state_nxt == S_DONE);

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE, S_DONE: begin
            if (w_accept)
               w_state_nxt = w_dbz ? S_DONE : (w_is_div ? S_DIV : S_MUL);
            else
               w_state_nxt = S_IDLE;
         end
         S_MUL: begin
`ifdef MULDIV_FAST_MUL_EN
            w_state_nxt = io_bus.annul ? S_IDLE : S_DONE;
`else
            if (io_bus.annul)
               w_state_nxt = S_IDLE;
            else if (w_last)
               w_state_nxt = S_DONE;
`endif
         end
         S_DIV: begin
            if (io_bus.annul)
               w_state_nxt = S_IDLE;
            else if (w_last)
               w_state_nxt = S_DONE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_resetn)
         r_state <= S_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_ff @(posedge i_clk) begin
      if (!i_resetn) begin
         r_cnt     <= '0;
         r_a       <= '0;
         r_b       <= '0;
         r_acc     <= '0;
         r_neg_q   <= 1'b0;
         r_neg_r   <= 1'b0;
         r_tag     <= '0;
         r_res_hi  <= '0;
         r_res_lo  <= '0;
         r_res_tag <= '0;
         r_dbz     <= 1'b0;
      end else if (w_accept) begin
         r_cnt   <= '0;
         r_a     <= w_mag1;
         r_b     <= w_mag2;
         r_acc   <= w_is_div ? {{WIDTH{1'b0}}, w_mag1} : {{WIDTH{1'b0}}, w_mag2};
         r_neg_q <= w_s1 ^ w_s2;
         r_neg_r <= w_s1;
         r_tag   <= io_bus.tag_in;
         // Divide by zero completes straight away with the raw dividend in HI.
         if (w_dbz) begin
            r_res_hi  <= io_bus.src1;
            r_res_lo  <= '1;
            r_res_tag <= io_bus.tag_in;
            r_dbz     <= 1'b1;
         end
      end else if (w_busy && !io_bus.annul) begin
         r_cnt <= r_cnt + CW'(1);
         r_acc <= w_step;
         if (w_finish) begin
            r_res_hi  <= (r_state == S_DIV) ? w_rem_fin : w_prod_fin[2*WIDTH-1:WIDTH];
            r_res_lo  <= (r_state == S_DIV) ? w_quo_fin : w_prod_fin[WIDTH-1:0];
            r_res_tag <= r_tag;
            r_dbz     <= 1'b0;
         end
      end
   end

   assign io_bus.op_ready    = w_ready;
   assign io_bus.busy        = w_busy;
   assign io_bus.res_valid   = (r_state == S_DONE);
   assign io_bus.res_hi      = r_res_hi;
   assign io_bus.res_lo      = r_res_lo;
   assign io_bus.res_tag     = r_res_tag;
   assign io_bus.div_by_zero = r_dbz;
endmodule
